// File: rtl/step_decoder_pkg.sv
// step_decoder_pkg
// Shared control definitions for the step decoder family.
//   step_mode_e  : output encoding selector (STEP_ONEHOT / STEP_THERMO)
//   MAX_SEL_W    : widest step index the shared decode helper supports
//   step_decode  : maps a step index to a one-hot or thermometer vector,
//                  sized for MAX_SEL_W; callers keep the low 2**SEL_W bits
package step_decoder_pkg;

    typedef enum logic {
        STEP_ONEHOT = 1'b0,
        STEP_THERMO = 1'b1
    } step_mode_e;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    // Bit b is set when it is the selected step (one-hot) or any step up to
    // and including the selected one (thermometer). Index 0 gives bit 0 only
    // in both encodings.
    function automatic logic [MAX_OUT_W-1:0] step_decode(
        input logic [MAX_SEL_W-1:0] idx,
        input logic                 mode
    );
        logic [MAX_OUT_W-1:0] v;
        v = '0;
        for (int b = 0; b < MAX_OUT_W; b++) begin
            if (mode == STEP_THERMO) begin
                v[b] = (b <= int'(idx));
            end else begin
                v[b] = (b == int'(idx));
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/step_decoder_index_decoder.sv
// index_decoder
// Purely combinational SEL_W to 2**SEL_W step decoder.
//   idx  in  SEL_W       step index to decode
//   mode in  1           0 = one-hot, 1 = thermometer
//   dec  out 2**SEL_W    decoded vector
module index_decoder
    import step_decoder_pkg::*;
#(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      idx,
    input  logic                  mode,
    output logic [2**SEL_W-1:0]   dec
);

    localparam int OUT_W = 2 ** SEL_W;

    logic [MAX_OUT_W-1:0] full;

    // The shared helper works at the widest supported size; the index is
    // zero-extended so the bits above OUT_W always come back clear.
    always_comb begin
        full = step_decode(MAX_SEL_W'(idx), mode);
    end

    assign dec = full[OUT_W-1:0];

    // Upper bits of the shared helper result are structurally unused here.
    if (OUT_W < MAX_OUT_W) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^full[MAX_OUT_W-1:OUT_W];
    end

endmodule

// File: rtl/step_decoder.sv
// step_decoder
// Step counter with programmable wrap point, direct load and synchronous
// clear, driving a registered one-hot or thermometer decode of the step.
//   clock     in   rising-edge clock
//   clear_n   in   asynchronous active-low reset
//   clr       in   synchronous clear to step 0 (highest priority)
//   load      in   load load_idx as the next step
//   load_idx  in   SEL_W step index to load
//   step      in   advance one step
//   mode      in   0 = one-hot, 1 = thermometer
//   index     out  SEL_W current step index
//   step_out  out  2**SEL_W decoded current step
//   last      out  high while index == LAST
//   wrapped   out  one-cycle pulse after a LAST->0 step
//   err       out  one-cycle pulse after an out-of-range load
module step_decoder
    import step_decoder_pkg::*;
#(
    parameter int SEL_W = 4,
    parameter int LAST  = 2 ** SEL_W - 1
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 clr,
    input  logic                 load,
    input  logic [SEL_W-1:0]     load_idx,
    input  logic                 step,
    input  logic                 mode,
    output logic [SEL_W-1:0]     index,
    output logic [2**SEL_W-1:0]  step_out,
    output logic                 last,
    output logic                 wrapped,
    output logic                 err
);

    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(LAST);

    logic [SEL_W-1:0] next_idx;
    logic             next_wrap;
    logic             next_err;
    logic [OUT_W-1:0] next_dec;

    // Next-step selection: clr beats load beats step beats hold. An
    // out-of-range load holds the index and flags err instead of stepping.
    always_comb begin
        next_idx  = index;
        next_wrap = 1'b0;
        next_err  = 1'b0;
        if (clr) begin
            next_idx = '0;
        end else if (load) begin
            if (load_idx > LAST_IDX) begin
                next_err = 1'b1;
            end else begin
                next_idx = load_idx;
            end
        end else if (step) begin
            if (index == LAST_IDX) begin
                next_idx  = '0;
                next_wrap = 1'b1;
            end else begin
                next_idx = index + SEL_W'(1);
            end
        end
    end

    // Decoding the next index (not the current one) lets the registered
    // step_out line up with index, and re-decodes on a mode change.
    index_decoder #(
        .SEL_W (SEL_W)
    ) u_index_decoder (
        .idx  (next_idx),
        .mode (mode),
        .dec  (next_dec)
    );

    // All outputs are flops so no input reaches an output combinationally.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            index    <= '0;
            step_out <= OUT_W'(1);
            last     <= (LAST == 0);
            wrapped  <= 1'b0;
            err      <= 1'b0;
        end else begin
            index    <= next_idx;
            step_out <= next_dec;
            last     <= (next_idx == LAST_IDX);
            wrapped  <= next_wrap;
            err      <= next_err;
        end
    end

endmodule

// File: tb/tb_step_decoder.sv
// tb_step_decoder
// Drives three step_decoder instances (LAST = 15, 5, 0) from shared inputs
// and checks them against an arithmetic model every cycle, plus directed
// literal expectations at the interesting points.
module tb_step_decoder;

    localparam int SEL_W = 4;
    localparam int NDUT  = 3;
    localparam int LASTS [NDUT] = '{15, 5, 0};

    logic        clock = 1'b0;
    logic        clear_n;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [3:0]  load_idx = '0;
    logic        step = 1'b0;
    logic        mode = 1'b0;

    logic [3:0]  idx_o  [NDUT];
    logic [15:0] out_o  [NDUT];
    logic        last_o [NDUT];
    logic        wrap_o [NDUT];
    logic        err_o  [NDUT];

    int checks = 0;
    int passes = 0;
    bit check_en = 1'b0;

    always #5 clock = ~clock;

    step_decoder #(.SEL_W(SEL_W), .LAST(15)) dut15 (
        .clock(clock), .clear_n(clear_n), .clr(clr), .load(load),
        .load_idx(load_idx), .step(step), .mode(mode),
        .index(idx_o[0]), .step_out(out_o[0]), .last(last_o[0]),
        .wrapped(wrap_o[0]), .err(err_o[0]));

    step_decoder #(.SEL_W(SEL_W), .LAST(5)) dut5 (
        .clock(clock), .clear_n(clear_n), .clr(clr), .load(load),
        .load_idx(load_idx), .step(step), .mode(mode),
        .index(idx_o[1]), .step_out(out_o[1]), .last(last_o[1]),
        .wrapped(wrap_o[1]), .err(err_o[1]));

    step_decoder #(.SEL_W(SEL_W), .LAST(0)) dut0 (
        .clock(clock), .clear_n(clear_n), .clr(clr), .load(load),
        .load_idx(load_idx), .step(step), .mode(mode),
        .index(idx_o[2]), .step_out(out_o[2]), .last(last_o[2]),
        .wrapped(wrap_o[2]), .err(err_o[2]));

    // Model state: current step number, the decoded value it implies and
    // the two event flags, one set per instance.
    int m_idx  [NDUT] = '{0, 0, 0};
    int m_out  [NDUT] = '{1, 1, 1};
    bit m_wrap [NDUT] = '{0, 0, 0};
    bit m_err  [NDUT] = '{0, 0, 0};

    // One-hot is a single shifted bit; thermometer is every bit up to i.
    function automatic int exp_out(input int i, input bit m);
        return m ? ((2 << i) - 1) : (1 << i);
    endfunction

    // The counter is a modulo-(LAST+1) step count with clear and load
    // overrides; an out-of-range load is only an error report.
    always @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int k = 0; k < NDUT; k++) begin
                m_idx[k] = 0; m_out[k] = 1; m_wrap[k] = 0; m_err[k] = 0;
            end
        end else begin
            for (int k = 0; k < NDUT; k++) begin
                m_wrap[k] = 0;
                m_err[k]  = 0;
                if (clr) begin
                    m_idx[k] = 0;
                end else if (load) begin
                    if (int'(load_idx) > LASTS[k]) m_err[k] = 1;
                    else m_idx[k] = int'(load_idx);
                end else if (step) begin
                    m_wrap[k] = (m_idx[k] == LASTS[k]);
                    m_idx[k]  = (m_idx[k] + 1) % (LASTS[k] + 1);
                end
                m_out[k] = exp_out(m_idx[k], mode);
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Every instance is compared against the model on every falling edge.
    always @(negedge clock) begin
        if (check_en && clear_n) begin
            for (int k = 0; k < NDUT; k++) begin
                checkOutput($sformatf("dut%0d index", k), int'(idx_o[k]), m_idx[k]);
                checkOutput($sformatf("dut%0d step_out", k), int'(out_o[k]), m_out[k]);
                checkOutput($sformatf("dut%0d last", k), int'(last_o[k]), int'(m_idx[k] == LASTS[k]));
                checkOutput($sformatf("dut%0d wrapped", k), int'(wrap_o[k]), int'(m_wrap[k]));
                checkOutput($sformatf("dut%0d err", k), int'(err_o[k]), int'(m_err[k]));
            end
        end
    end

    task automatic applyStimulus(input bit c, input bit l, input int li, input bit s, input bit m);
        clr = c; load = l; load_idx = 4'(li); step = s; mode = m;
    endtask

    task automatic cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        clear_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("reset index", int'(idx_o[0]), 0);
        checkOutput("reset step_out", int'(out_o[0]), 'h0001);
        checkOutput("reset last15", int'(last_o[0]), 0);
        checkOutput("reset last0", int'(last_o[2]), 1);
        checkOutput("reset wrapped", int'(wrap_o[0]), 0);
        checkOutput("reset err", int'(err_o[0]), 0);
        clear_n  = 1'b1;
        check_en = 1'b1;

        // 16 one-hot steps on LAST=15; LAST=0 wraps on every step
        applyStimulus(0, 0, 0, 1, 0);
        cycle();
        checkOutput("first step index", int'(idx_o[0]), 1);
        checkOutput("last0 step wrapped", int'(wrap_o[2]), 1);
        repeat (14) cycle();
        checkOutput("at 15 step_out", int'(out_o[0]), 'h8000);
        checkOutput("at 15 last", int'(last_o[0]), 1);
        checkOutput("at 15 wrapped", int'(wrap_o[0]), 0);
        cycle();
        checkOutput("wrap step_out", int'(out_o[0]), 'h0001);
        checkOutput("wrap pulse", int'(wrap_o[0]), 1);
        cycle();
        checkOutput("wrap drop", int'(wrap_o[0]), 0);

        // Thermometer run on LAST=5
        applyStimulus(1, 0, 0, 0, 1);
        cycle();
        applyStimulus(0, 0, 0, 1, 1);
        cycle();
        checkOutput("thermo idx1", int'(out_o[1]), 'h0003);
        repeat (4) cycle();
        checkOutput("thermo idx5", int'(out_o[1]), 'h003F);
        checkOutput("thermo last", int'(last_o[1]), 1);
        cycle();
        checkOutput("thermo wrap out", int'(out_o[1]), 'h0001);
        checkOutput("thermo wrap pulse", int'(wrap_o[1]), 1);

        // Load beats step; clr beats both
        applyStimulus(0, 1, 7, 0, 0);
        cycle();
        checkOutput("load 7", int'(idx_o[0]), 7);
        applyStimulus(0, 1, 3, 1, 0);
        cycle();
        checkOutput("load wins", int'(idx_o[0]), 3);
        applyStimulus(1, 1, 5, 1, 0);
        cycle();
        checkOutput("clr wins index", int'(idx_o[0]), 0);
        checkOutput("clr wins wrapped0", int'(wrap_o[2]), 0);
        checkOutput("clr wins err", int'(err_o[1]), 0);

        // Illegal load on LAST=5 then a legal one
        applyStimulus(0, 1, 2, 0, 0);
        cycle();
        applyStimulus(0, 1, 9, 1, 0);
        cycle();
        checkOutput("illegal hold", int'(idx_o[1]), 2);
        checkOutput("illegal err", int'(err_o[1]), 1);
        applyStimulus(0, 1, 4, 0, 0);
        cycle();
        checkOutput("legal after err", int'(idx_o[1]), 4);
        checkOutput("err drop", int'(err_o[1]), 0);

        // Mode flip while holding at 4
        applyStimulus(0, 0, 0, 0, 0);
        cycle();
        checkOutput("hold onehot", int'(out_o[1]), 'h0010);
        applyStimulus(0, 0, 0, 0, 1);
        cycle();
        checkOutput("flip thermo", int'(out_o[1]), 'h001F);
        checkOutput("flip index", int'(idx_o[1]), 4);

        // Asynchronous clear between edges at index 9
        applyStimulus(0, 1, 9, 0, 0);
        cycle();
        applyStimulus(0, 0, 0, 0, 0);
        @(posedge clock);
        #2 clear_n = 1'b0;
        #1;
        checkOutput("async index", int'(idx_o[0]), 0);
        checkOutput("async step_out", int'(out_o[0]), 'h0001);
        checkOutput("async wrapped", int'(wrap_o[0]), 0);
        checkOutput("async err", int'(err_o[0]), 0);
        #1 clear_n = 1'b1;
        @(negedge clock);
        applyStimulus(0, 0, 0, 1, 0);
        cycle();
        checkOutput("resume index", int'(idx_o[0]), 1);
        checkOutput("resume step_out", int'(out_o[0]), 'h0002);

        applyStimulus(0, 0, 0, 0, 0);
        cycle();
        check_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
